// File: rtl/bin2bcd_converter_pkg.sv
// Shared constants for the binary-to-BCD converter: FSM encoding, digit limits
// and a helper that computes the full-scale decimal value for a digit count.
package bcd_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [3:0] BCD_MAX_DIGIT  = 4'd9;
    localparam logic [3:0] ADD3_THRESHOLD = 4'd5;

    // Largest value representable in 'digits' decimal digits (10^digits - 1).
    function automatic logic [63:0] full_scale(input int digits);
        logic [63:0] value;
        value = 64'd1;
        for (int i = 0; i < digits; i++) begin
            value = value * 64'd10;
        end
        return value - 64'd1;
    endfunction

endpackage

// File: rtl/bin2bcd_converter_if.sv
// Request/complete handshake and result bus between a requester and the
// binary-to-BCD converter.
interface bin2bcd_converter_if #(
    parameter int BIN_WIDTH = 14,
    parameter int DIGITS    = 4
);

    logic                  start;
    logic [BIN_WIDTH-1:0]  binary;
    logic                  busy;
    logic                  done;
    logic                  overflow;
    logic [4*DIGITS-1:0]   bcd;

    modport master (
        output start,
        output binary,
        input  busy,
        input  done,
        input  overflow,
        input  bcd
    );

    modport slave (
        input  start,
        input  binary,
        output busy,
        output done,
        output overflow,
        output bcd
    );

endinterface

// File: rtl/bin2bcd_converter_add3.sv
// Single-digit double-dabble correction: digits of 5 or more get +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    assign digit_o = (digit_i >= ADD3_THRESHOLD) ? (digit_i + 4'd3) : digit_i;

endmodule

// File: rtl/bin2bcd_converter.sv
// Sequential shift-and-add-3 binary-to-BCD converter with a registered,
// glitch-free result that only updates on the completion pulse.
module bin2bcd_converter
    import bcd_pkg::*;
#(
    parameter int BIN_WIDTH = 14,
    parameter int DIGITS    = 4
) (
    input  logic                 clk,
    input  logic                 reset_,
    bin2bcd_converter_if.slave   bus
);

    localparam int              CNT_W      = $clog2(BIN_WIDTH + 1);
    localparam int              SCR_W      = 4 * DIGITS;
    localparam logic [63:0]     FULL_SCALE = full_scale(DIGITS);

    logic [1:0]           state_q,    state_d;
    logic [CNT_W-1:0]     cnt_q,      cnt_d;
    logic [BIN_WIDTH-1:0] shift_q,    shift_d;
    logic [SCR_W-1:0]     scratch_q,  scratch_d;
    logic                 ovf_pend_q, ovf_pend_d;
    logic [SCR_W-1:0]     bcd_q,      bcd_d;
    logic                 overflow_q, overflow_d;
    logic                 done_q,     done_d;

    logic [SCR_W-1:0]     corrected;
    logic [63:0]          binary_ext;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .digit_i (scratch_q[4*g +: 4]),
            .digit_o (corrected[4*g +: 4])
        );
    end

    assign binary_ext = {{(64-BIN_WIDTH){1'b0}}, bus.binary};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        scratch_d  = scratch_q;
        ovf_pend_d = ovf_pend_q;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    shift_d    = bus.binary;
                    scratch_d  = '0;
                    cnt_d      = CNT_W'(BIN_WIDTH);
                    ovf_pend_d = (binary_ext > FULL_SCALE);
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Correction happens before the shift; the MSB falling out of
                // the scratch register is only ever non-zero on overflow.
                {scratch_d, shift_d} = {corrected, shift_q} << 1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                bcd_d      = ovf_pend_q ? {DIGITS{BCD_MAX_DIGIT}} : scratch_q;
                overflow_d = ovf_pend_q;
                done_d     = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            scratch_q  <= '0;
            ovf_pend_q <= 1'b0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            scratch_q  <= scratch_d;
            ovf_pend_q <= ovf_pend_d;
            bcd_q      <= bcd_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    assign bus.busy     = (state_q == ST_SHIFT) || (state_q == ST_DONE);
    assign bus.done     = done_q;
    assign bus.overflow = overflow_q;
    assign bus.bcd      = bcd_q;

endmodule
